// File: rtl/dm_ctrl_pkg.sv
// dm_ctrl_pkg: shared types and constants for the data-memory controller.
//   dm_state_e       : controller FSM states
//   DM_TIMEOUT_DATA  : load result returned when memory never acknowledges
//   DM_MISALIGN_DATA : load result returned for a misaligned load
package dm_ctrl_pkg;

    localparam int unsigned DM_DATA_W = 32;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_DONE = 2'd2
    } dm_state_e;

    localparam logic [DM_DATA_W-1:0] DM_TIMEOUT_DATA  = 32'hFFFF_FFFF;
    localparam logic [DM_DATA_W-1:0] DM_MISALIGN_DATA = 32'h0000_0000;

endpackage

// File: rtl/dm_ctrl_wait_timer.sv
// wait_timer: clearable up-counter that measures cycles spent waiting for ack.
//   clk, reset : clock, synchronous active-low reset
//   clr_i      : force count to zero (held while not waiting)
//   en_i       : count up this cycle
//   expired_c  : count has reached TIMEOUT-1 (combinational)
module wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c
);

    // At least one bit so TIMEOUT=1 still elaborates.
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/dm_ctrl.sv
// dm_ctrl: bridges the CPU data-memory port to a req/ack synchronous memory.
//   CPU side    : dm_read, dm_write, read/write addresses, data_to_dm in;
//                 data_from_dm (registered), stall (combinational) out
//   Errors      : err_misaligned, err_timeout (sticky until reset)
//   Memory side : mem_req, mem_we, mem_addr, mem_wdata out (registered);
//                 mem_rdata, mem_ack in
module dm_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dm_read,
    input  logic          dm_write,
    input  logic [AW-1:0] read_address_to_dm,
    input  logic [AW-1:0] write_address_to_dm,
    input  logic [DW-1:0] data_to_dm,
    output logic [DW-1:0] data_from_dm,
    output logic          stall,
    output logic          err_misaligned,
    output logic          err_timeout,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    dm_state_e     state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          errm_q, errm_d;
    logic          errt_q, errt_d;

    logic          stall_c;
    logic          tmr_clr_c;
    logic          tmr_en_c;
    logic          tmr_expired_c;
    logic [AW-1:0] sel_addr_c;

    // Timer idles at zero outside WAIT, so it is cleared on WAIT entry.
    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (tmr_clr_c),
        .en_i      (tmr_en_c),
        .expired_c (tmr_expired_c)
    );

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        errm_d     = errm_q;
        errt_d     = errt_q;
        stall_c    = 1'b0;
        tmr_clr_c  = 1'b1;
        tmr_en_c   = 1'b0;
        // Store wins when both requests are raised together.
        sel_addr_c = dm_write ? write_address_to_dm : read_address_to_dm;

        unique case (state_q)
            DM_IDLE: begin
                if (dm_write || dm_read) begin
                    stall_c = 1'b1;
                    we_d    = dm_write;
                    addr_d  = sel_addr_c;
                    wdata_d = data_to_dm;
                    if (sel_addr_c[1:0] != 2'b00) begin
                        // Misaligned: no bus access, finish immediately.
                        errm_d  = 1'b1;
                        state_d = DM_DONE;
                        if (!dm_write) begin
                            rdata_d = DW'(DM_MISALIGN_DATA);
                        end
                    end else begin
                        req_d   = 1'b1;
                        state_d = DM_WAIT;
                    end
                end
            end
            DM_WAIT: begin
                stall_c   = 1'b1;
                tmr_clr_c = 1'b0;
                tmr_en_c  = 1'b1;
                // Ack beats a timeout landing in the same cycle.
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = DM_DONE;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else if (tmr_expired_c) begin
                    req_d   = 1'b0;
                    errt_d  = 1'b1;
                    state_d = DM_DONE;
                    if (!we_q) begin
                        rdata_d = DW'(DM_TIMEOUT_DATA);
                    end
                end
            end
            DM_DONE: begin
                // Held requests are ignored here so they are not reissued.
                state_d = DM_IDLE;
            end
            default: begin
                state_d = DM_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= DM_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            errm_q  <= 1'b0;
            errt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            errm_q  <= errm_d;
            errt_q  <= errt_d;
        end
    end

    assign data_from_dm   = rdata_q;
    assign stall          = stall_c;
    assign err_misaligned = errm_q;
    assign err_timeout    = errt_q;
    assign mem_req        = req_q;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: directed + randomized checks of dm_ctrl against a transaction-level model.
module tb_dm_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] read_address_to_dm;
    logic [31:0] write_address_to_dm;
    logic [31:0] data_to_dm;
    logic [31:0] data_from_dm;
    logic        stall;
    logic        err_misaligned;
    logic        err_timeout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_chk = 0;
    int n_err = 0;

    // Transaction-level model state.
    logic [31:0] exp_rd;
    logic        exp_errm;
    logic        exp_errt;

    dm_ctrl #(.DW(32), .AW(32), .TIMEOUT(TO)) dut (
        .clk                 (clk),
        .reset               (reset),
        .dm_read             (dm_read),
        .dm_write            (dm_write),
        .read_address_to_dm  (read_address_to_dm),
        .write_address_to_dm (write_address_to_dm),
        .data_to_dm          (data_to_dm),
        .data_from_dm        (data_from_dm),
        .stall               (stall),
        .err_misaligned      (err_misaligned),
        .err_timeout         (err_timeout),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_rdata           (mem_rdata),
        .mem_ack             (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_stall"}, 64'(stall), 64'd0);
        chk({tag, "_req"},   64'(mem_req), 64'd0);
        chk({tag, "_data"},  64'(data_from_dm), 64'(exp_rd));
        chk({tag, "_errm"},  64'(err_misaligned), 64'(exp_errm));
        chk({tag, "_errt"},  64'(err_timeout), 64'(exp_errt));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset    = 1'b0;
        dm_read  = 1'b0;
        dm_write = 1'b0;
        mem_ack  = 1'b0;
        @(posedge clk); #1;
        reset    = 1'b1;
        exp_rd   = '0;
        exp_errm = 1'b0;
        exp_errt = 1'b0;
        @(negedge clk);
        idle_checks("rst");
        chk("rst_we",    64'(mem_we), 64'd0);
        chk("rst_addr",  64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
    endtask

    // One CPU access; ack_cyc = cycle of the ack pulse (0 = none), rd_val = data returned with it.
    task automatic access(input bit w, input bit r, input logic [31:0] ra, input logic [31:0] wa,
                          input logic [31:0] wd, input int ack_cyc, input logic [31:0] rd_val);
        logic [31:0] a;
        logic [31:0] prev;
        bit          mis;
        int          last;
        a    = w ? wa : ra;
        mis  = (a[1:0] != 2'b00);
        last = (ack_cyc >= 1 && ack_cyc <= int'(TO)) ? ack_cyc : int'(TO);
        prev = exp_rd;

        @(posedge clk); #1;
        dm_write            = w;
        dm_read             = r;
        read_address_to_dm  = ra;
        write_address_to_dm = wa;
        data_to_dm          = wd;
        mem_ack             = 1'b0;
        mem_rdata           = $urandom;
        @(negedge clk);
        chk("c0_stall", 64'(stall), 64'd1);
        chk("c0_req",   64'(mem_req), 64'd0);

        if (mis) begin
            @(posedge clk); #1;
            mem_rdata = $urandom;
            mem_ack   = (ack_cyc == 1);
            exp_errm  = 1'b1;
            if (!w) exp_rd = 32'h0;
            @(negedge clk);
            idle_checks("mis_done");
        end else begin
            for (int c = 1; c <= last + 1; c++) begin
                @(posedge clk); #1;
                mem_ack   = (c == ack_cyc);
                mem_rdata = (c == ack_cyc) ? rd_val : 32'($urandom);
                @(negedge clk);
                if (c <= last) begin
                    chk("w_req",   64'(mem_req), 64'd1);
                    chk("w_we",    64'(mem_we), 64'(w));
                    chk("w_addr",  64'(mem_addr), 64'(a));
                    chk("w_wdata", 64'(mem_wdata), 64'(wd));
                    chk("w_stall", 64'(stall), 64'd1);
                    chk("w_data",  64'(data_from_dm), 64'(prev));
                end else begin
                    if (ack_cyc >= 1 && ack_cyc <= int'(TO)) begin
                        if (!w) exp_rd = rd_val;
                    end else begin
                        exp_errt = 1'b1;
                        if (!w) exp_rd = 32'hFFFF_FFFF;
                    end
                    idle_checks("done");
                end
            end
        end

        // Release the request; a stray ack in IDLE must have no effect.
        @(posedge clk); #1;
        dm_write  = 1'b0;
        dm_read   = 1'b0;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        idle_checks("after");
    endtask

    initial begin
        reset = 1'b0; dm_read = 1'b0; dm_write = 1'b0; mem_ack = 1'b0;
        read_address_to_dm = '0; write_address_to_dm = '0; data_to_dm = '0; mem_rdata = '0;
        exp_rd = '0; exp_errm = 1'b0; exp_errt = 1'b0;
        do_reset();

        // Aligned write, ack in cycle 3.
        access(1'b1, 1'b0, 32'h0, 32'h10, 32'hCAFE_BABE, 3, 32'h0);
        // Aligned read, ack in cycle 1.
        access(1'b0, 1'b1, 32'h20, 32'h0, 32'h0, 1, 32'h1234_5678);
        // Following write must not disturb the load result.
        access(1'b1, 1'b0, 32'h0, 32'h14, 32'h5555_AAAA, 2, 32'hDEAD_0000);
        // Simultaneous request resolves as a write to the store address.
        access(1'b1, 1'b1, 32'h34, 32'h30, 32'h0BAD_F00D, 1, 32'h0);
        // Misaligned read.
        access(1'b0, 1'b1, 32'h22, 32'h0, 32'h0, 1, 32'h7777_7777);
        // Ack in the last possible WAIT cycle beats the timeout.
        access(1'b0, 1'b1, 32'h44, 32'h0, 32'h0, int'(TO), 32'h0F0F_0F0F);
        // Timeout on a read, late ack lands in DONE.
        access(1'b0, 1'b1, 32'h48, 32'h0, 32'h0, int'(TO) + 1, 32'h1111_1111);

        // Reset while in WAIT.
        @(posedge clk); #1;
        dm_read = 1'b1; read_address_to_dm = 32'h60;
        @(posedge clk); #1;
        reset = 1'b0; dm_read = 1'b0;
        @(negedge clk);
        chk("rw_req_before", 64'(mem_req), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_rd = '0; exp_errm = 1'b0; exp_errt = 1'b0;
        @(negedge clk);
        idle_checks("rw");
        chk("rw_we",    64'(mem_we), 64'd0);
        chk("rw_addr",  64'(mem_addr), 64'd0);
        chk("rw_wdata", 64'(mem_wdata), 64'd0);
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hABCD_EF01;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        idle_checks("rw_lateack");

        // Randomized accesses.
        for (int i = 0; i < 80; i++) begin
            bit          w, r;
            logic [31:0] ra, wa;
            int          sel;
            if (i % 20 == 19) do_reset();
            sel = $urandom_range(0, 2);
            w   = (sel != 0);
            r   = (sel != 1);
            ra  = $urandom;
            wa  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                ra[1:0] = 2'b00;
                wa[1:0] = 2'b00;
            end
            access(w, r, ra, wa, 32'($urandom), $urandom_range(0, TO + 1), 32'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
